// File: rtl/shift_left_sequential_pkg.sv
// Shared encodings for the sequential left shifter/rotator: FSM states and
// operation selects.
package shift_left_sequential_pkg;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic OpRol = 1'b0;
  localparam logic OpSll = 1'b1;

endpackage

// File: rtl/shift_left_step.sv
// One-bit left step: rotate (MSB wraps into LSB) or logical shift (zero fill).
module shift_left_step
  import shift_left_sequential_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] In,
  input  logic             Op,
  output logic [WIDTH-1:0] Out
);

  always_comb begin
    Out = {In[WIDTH-2:0], (Op == OpRol) ? In[WIDTH-1] : 1'b0};
  end

endmodule

// File: rtl/shift_left_sequential.sv
// Multi-cycle left shifter/rotator: one bit position per clock, one-cycle done
// pulse on completion, result held until the next accepted request.
module shift_left_sequential
  import shift_left_sequential_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    In,
  input  logic [CntWidth-1:0] Cnt,
  input  logic                Op,
  output logic [WIDTH-1:0]    Out,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] rem_q, rem_d;
  logic                op_q, op_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [WIDTH-1:0]    step_out;

  shift_left_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .In  (out_q),
    .Op  (op_q),
    .Out (step_out)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          out_d = In;
          // A zero count skips SHIFT entirely, so rem never wraps.
          if (Cnt != '0) begin
            rem_d   = Cnt;
            op_d    = Op;
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        out_d = step_out;
        rem_d = rem_q - CntWidth'(1);
        if (rem_q == CntWidth'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      op_q    <= OpRol;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q == StShift) || (state_q == StDone);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_shift_left_sequential.sv
// Scoreboard bench for shift_left_sequential: stimulus queues expected results,
// a monitor pops and checks them on every done pulse.
module tb_shift_left_sequential;

  typedef struct {
    logic [15:0] out;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in_v;
  logic [3:0]  cnt_v;
  logic        op_v;
  logic [15:0] out_v;
  logic        busy_v;
  logic        done_v;

  int   total;
  int   bad;
  int   cyc;
  exp_t sb[$];

  shift_left_sequential #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (in_v),
    .Cnt   (cnt_v),
    .Op    (op_v),
    .Out   (out_v),
    .busy  (busy_v),
    .done  (done_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_v === 1'b1) begin
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_done: got done=1 with Out=%h, required no done", out_v);
        end else begin
          e = sb.pop_front();
          if (out_v !== e.out) begin
            bad = bad + 1;
            $display("FAIL %s_out: got %h, required %h", e.name, out_v, e.out);
          end
          total = total + 1;
          if (cyc - e.acc + 1 != e.lat) begin
            bad = bad + 1;
            $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.acc + 1, e.lat);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    total = total + 1;
    if (got !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Waits for idle, presents one request for one edge; returns at the negedge
  // after the accepting edge with start low again.
  task automatic issue(input string name, input logic op, input logic [3:0] cnt,
                       input logic [15:0] din, input logic [15:0] exp_out, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy_v !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s_wait_idle: got busy=%b, required 0 within 40 cycles", name, busy_v);
    end
    start = 1'b1;
    op_v  = op;
    cnt_v = cnt;
    in_v  = din;
    if (track) begin
      e.out  = exp_out;
      e.lat  = int'(cnt) + 1;
      e.acc  = cyc + 1;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in_v  = 16'hDEAD;
    cnt_v = 4'hF;
    op_v  = ~op;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b1;
    op_v  = 1'b1;
    cnt_v = 4'd3;
    in_v  = 16'hBEEF;

    // Reset wins over start for two cycles.
    repeat (2) @(negedge clk);
    check("reset_out", out_v, 16'h0000);
    check("reset_busy", {15'd0, busy_v}, 16'h0000);
    check("reset_done", {15'd0, done_v}, 16'h0000);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_no_accept", {15'd0, busy_v}, 16'h0000);

    // SLL by 1: busy for exactly two cycles.
    issue("sll1", 1'b1, 4'd1, 16'h8001, 16'h0002, 1'b1);
    check("sll1_busy_c1", {15'd0, busy_v}, 16'h0001);
    @(negedge clk);
    check("sll1_busy_c2", {15'd0, busy_v}, 16'h0001);
    @(negedge clk);
    check("sll1_busy_c3", {15'd0, busy_v}, 16'h0000);

    issue("rol4", 1'b0, 4'd4, 16'h8001, 16'h0018, 1'b1);
    issue("zero_rol", 1'b0, 4'd0, 16'hA5A5, 16'hA5A5, 1'b1);
    issue("zero_sll", 1'b1, 4'd0, 16'hA5A5, 16'hA5A5, 1'b1);
    issue("rol1", 1'b0, 4'd1, 16'h8000, 16'h0001, 1'b1);
    issue("rol15", 1'b0, 4'd15, 16'h8001, 16'hC000, 1'b1);
    issue("sll8", 1'b1, 4'd8, 16'h1234, 16'h3400, 1'b1);

    // SLL by 15 with a second start pulsed mid-operation, which must be ignored.
    issue("sll15", 1'b1, 4'd15, 16'hFFFF, 16'h8000, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    in_v  = 16'h1234;
    cnt_v = 4'd3;
    op_v  = 1'b0;
    @(negedge clk);
    start = 1'b0;

    // ROL by 8 aborted by reset on the third shift cycle; never completes.
    issue("rol8_abort", 1'b0, 4'd8, 16'h1234, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out", out_v, 16'h0000);
    check("abort_busy", {15'd0, busy_v}, 16'h0000);
    check("abort_done", {15'd0, done_v}, 16'h0000);

    issue("sll2_after_abort", 1'b1, 4'd2, 16'h0003, 16'h000C, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_left_sequential.md
# shift_left_sequential

Multi-cycle left shifter/rotator for the 16-bit datapath. It is the left-direction counterpart of the combinational arithmetic right shifter. The block accepts one operand and count per request and shifts one bit position per clock. It signals completion with a one-cycle `done` pulse. It sits beside the execute-stage ALU and is used where a low-area shift path is preferred over a full barrel shifter.

## Interface
- `WIDTH`, 16: data width; the count width is fixed at 4 bits, so the supported shift range is 0–15.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `start` input 1: request strobe. Sampled only when `busy`=0.
- `In` input 16: operand, latched on an accepted `start`.
- `Cnt` input 4: shift amount, latched on an accepted `start`.
- `Op` input 1: operation select, latched on an accepted `start`. 0 = rotate left (ROL), 1 = shift left logical (SLL, zero fill).
- `Out` output 16: result register. Valid while `done`=1 and held until the next accepted `start`.
- `busy` output 1: high in SHIFT and DONE states.
- `done` output 1: one-cycle completion pulse.

## Operation
- States are IDLE, SHIFT and DONE. The encoding lives in the shared package.
- IDLE:
  - If `start`=1 and `Cnt`≠0: `Out`←`In`, `rem`←`Cnt`, latch `Op`, go to SHIFT.
  - If `start`=1 and `Cnt`=0: `Out`←`In`, go to DONE.
  - Otherwise hold.
- SHIFT, on each edge:
  - `Out`←step(`Out`, `Op`) and `rem`←`rem`−1.
  - If `rem`=1 before the decrement, go to DONE.
  - step is defined as follows. ROL: {Out[14:0], Out[15]}. SLL: {Out[14:0], 1'b0}.
- DONE: `done`=1 for exactly this cycle. The next edge always goes to IDLE.
- `start` is ignored while `busy`=1, in both SHIFT and DONE. The latched operands are not disturbed.
- `In`, `Cnt` and `Op` may change freely after acceptance without effect.
- `rem` is a 4-bit counter. It never wraps, because Cnt=0 bypasses SHIFT.
- Equivalence: the final `Out` equals `In << Cnt` for SLL and `(In << Cnt) | (In >> (16−Cnt))` for ROL, all 16-bit.

## Timing
- Reset values: `Out`=16'h0000, `busy`=0, `done`=0, state=IDLE, `rem`=0.
- Reset mid-operation: the next edge forces the reset values and the operation is discarded.
- `rst` and `start` high together: reset wins and the request is dropped.
- Let E0 be the edge that accepts `start`:
  - Shifts occur on edges E1 through E(Cnt).
  - `done` is high in the cycle following edge E(Cnt). For Cnt=0, that is the cycle right after E0.
  - Total latency from accepted start to done is Cnt+1 cycles. The worst case (Cnt=15) is 16.
- `busy` rises in the cycle after E0 and falls together with `done` at the edge leaving DONE.
- The earliest next request is therefore accepted on the edge after the DONE cycle. Back-to-back throughput is Cnt+2 cycles per op.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Structure
- The shared package holds:
  - the state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE);
  - the operation constants OP_ROL=1'b0 and OP_SLL=1'b1.
- Sub-module `shift_left_step`: purely combinational one-bit ROL/SLL step with ports (`In`[15:0], `Op`, `Out`[15:0]). It is instantiated once and feeds the `Out` register.
- The top level contains the state register, the `rem` counter, the latched `Op` and the `Out` register, all built from the team's synchronous-reset flop cells.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → `Out`=0x0000, `busy`=0, `done`=0, and no op is accepted.
- SLL, Cnt=1, In=0x8001 → `done` in the 2nd cycle after acceptance, `Out`=0x0002; `busy` is high for 2 cycles.
- ROL, Cnt=4, In=0x8001 → `done` 5 cycles after acceptance, `Out`=0x0018.
- Cnt=0, In=0xA5A5, either Op → `done` in the cycle right after acceptance, `Out`=0xA5A5.
- SLL, Cnt=15, In=0xFFFF, plus a second `start` (In=0x1234) pulsed mid-operation → the second request is ignored, `Out`=0x8000, and `done` arrives 16 cycles after acceptance.
- ROL, Cnt=8, In=0x1234, with `rst` pulsed on the 3rd shift cycle → outputs are zero the next cycle. Then `start` with SLL, Cnt=2, In=0x0003 → `Out`=0x000C and `done` arrives 3 cycles after acceptance.
